mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised arbiter/controller that shares one single-port RAM interface among NCH requesters, e.g. instruction fetch, data load/store, and DMA/debug.
- Latches the granted request, holds the RAM command stable until the RAM deasserts busy, then pulses that channel's ready.
- Supports fixed-priority or round-robin arbitration and an optional per-access timeout that completes the access with an error flag.
- Sits between the core's memory-facing stages and the RAM/bus model, replacing the two-channel I/D controller.

Parameters:
- NCH, 2, number of requester channels (1..8); channel 0 is highest fixed priority.
- AW, 32, address width.
- DW, 32, data width.
- MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT, 0, max busy cycles per access before abort; 0 = disabled.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- ch_ren  input  NCH  per-channel read request.
- ch_wen  input  NCH  per-channel write request.
- ch_addr  input  NCH*AW  packed addresses; channel i at [i*AW +: AW].
- ch_wdata  input  NCH*DW  packed write data.
- ch_ready  output  NCH  one-hot, one-cycle completion pulse.
- ch_err  output  NCH  one-hot, asserted with ch_ready when the access timed out.
- ch_rdata  output  DW  read data, valid only in the cycle ch_ready pulses for a read.
- ram_ren  output  1  RAM read strobe.
- ram_wen  output  1  RAM write strobe.
- ram_addr  output  AW  RAM address.
- ram_wdata  output  DW  RAM write data.
- ram_rdata  input  DW  RAM read data, valid when ram_busy = 0.
- ram_busy  input  1  RAM not yet done with the current command.

Behaviour:
- Reset (async, nRST=0):
  - State IDLE; all outputs 0.
  - Grant index 0; round-robin pointer 0; wait counter 0.
  - Latched addr/wdata/op cleared.
  - Reset mid-ACCESS aborts the access with no ready pulse.
- Requests:
  - Channel i requests when ch_ren[i] | ch_wen[i].
  - If both are set, the access is a write.
  - A requester holds addr, wdata and strobes until its ready pulse.
- State IDLE:
  - RAM strobes 0, ram_addr 0, ram_wdata 0.
  - If any channel requests, select a winner and latch its index, op, addr and wdata. Next state ACCESS.
  - MODE 0: lowest requesting index wins.
  - MODE 1: first requesting index at or after rr_ptr, wrapping NCH-1 -> 0.
  - rr_ptr updates to (winner+1) mod NCH on the completion cycle.
- State ACCESS:
  - Drive ram_ren/ram_wen, ram_addr and ram_wdata from the latched values. These are stable for the whole access, independent of live channel inputs.
  - Normal completion: in any cycle with ram_busy=0, pulse ch_ready[grant]=1. For a read, drive ch_rdata = ram_rdata (combinational pass-through). Next state IDLE.
  - Wait counter: increments each ACCESS cycle with ram_busy=1.
  - Timeout (TIMEOUT>0): if ram_busy=1 and the counter equals TIMEOUT-1, pulse ch_ready[grant] and ch_err[grant], force ch_rdata=0, deassert RAM strobes next cycle, go to IDLE.
  - Counter clears on entry to IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle n -> RAM strobe at n+1 -> ready at n+1+k, where k = busy cycles.
  - One idle bubble separates back-to-back accesses; peak throughput is 1 access per 2 cycles.
- Outputs:
  - ch_ready/ch_err are 0 in all other cycles and are never multi-hot.
  - ch_rdata is 0 when no read completes.
- Boundaries:
  - A channel that drops its request mid-ACCESS: the access still completes (write is committed) and ready still pulses.
  - New requests arriving during ACCESS are ignored until IDLE.
  - NCH=1 degenerates to a pass-through with a 1-cycle latch.
  - Round-robin pointer wrap at NCH-1 must select channel 0 next when it requests.

Test Plan:
- Fixed priority, NCH=3, MODE=0, ram_busy=0: ch_ren=3'b111 held -> grants 0,0,0…; drop ch0 after its ready -> channel 1 granted; ready pulses exactly 2 cycles apart.
- Round-robin, NCH=3, MODE=1: all channels request continuously -> grant order 0,1,2,0,1,2; no channel waits more than 3 accesses.
- Read with wait states: ch1 read addr 0x40, ram_busy=1 for 3 cycles, ram_rdata=0xDEADBEEF -> ram_addr=0x40 stable for 4 cycles; ch_ready[1] and ch_rdata=0xDEADBEEF in the 4th ACCESS cycle.
- Write: ch0 write addr 0x100, data 0x12345678 -> ram_wen=1, ram_ren=0, ram_wdata=0x12345678; ch_wdata changed mid-access does not alter ram_wdata; ch_ready[0] on completion. Simultaneous ren+wen on one channel -> write.
- Timeout, TIMEOUT=4: ram_busy stuck at 1 -> in the 4th ACCESS cycle ch_ready[g]=ch_err[g]=1 and ch_rdata=0; back to IDLE; the next request is served normally.
- Reset mid-access: nRST low during ACCESS -> all outputs 0 immediately; no ready pulse; after release, a pending request is granted fresh from IDLE and rr_ptr restarts at 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM among NCH requesters; fixed-priority or round-robin grant, optional busy timeout.
// Latency: request in IDLE -> strobe next cycle -> ready when ram_busy drops; requesters stall until their ready pulse.
module mem_port_arbiter #(
   parameter int NCH     = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MODE    = 0,
   parameter int TIMEOUT = 0
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [NCH-1:0]    ch_ren,
   input  logic [NCH-1:0]    ch_wen,
   input  logic [NCH*AW-1:0] ch_addr,
   input  logic [NCH*DW-1:0] ch_wdata,
   output logic [NCH-1:0]    ch_ready,
   output logic [NCH-1:0]    ch_err,
   output logic [DW-1:0]     ch_rdata,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [AW-1:0]     ram_addr,
   output logic [DW-1:0]     ram_wdata,
   input  logic [DW-1:0]     ram_rdata,
   input  logic              ram_busy
);

   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t         state;
   logic [GW-1:0]  grant;
   logic [GW-1:0]  rr_ptr;
   logic           op_wr;
   logic [AW-1:0]  addr_q;
   logic [DW-1:0]  wdata_q;
   logic [CW-1:0]  wait_cnt;

   logic [NCH-1:0] req;
   logic [GW-1:0]  winner;
   logic           found;
   logic           to_hit;
   logic           done;
   logic [GW-1:0]  next_ptr;

   assign req = ch_ren | ch_wen;

   // Scan starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         idx = (MODE == 1) ? ((int'(rr_ptr) + k) % NCH) : k;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = GW'(idx);
         end
      end
   end

   assign to_hit   = (TIMEOUT > 0) && ram_busy && (wait_cnt == CW'(TIMEOUT - 1));
   assign done     = (state == ACCESS) && (!ram_busy || to_hit);
   assign next_ptr = (grant == GW'(NCH - 1)) ? '0 : grant + GW'(1);

   always_comb begin
      ch_ready = '0;
      ch_err   = '0;
      if (done) begin
         ch_ready[grant] = 1'b1;
         ch_err[grant]   = to_hit;
      end
   end

   // Read data passes straight through on a good read completion; zero otherwise.
   assign ch_rdata  = (done && !op_wr && !to_hit) ? ram_rdata : '0;
   assign ram_ren   = (state == ACCESS) && !op_wr;
   assign ram_wen   = (state == ACCESS) && op_wr;
   assign ram_addr  = (state == ACCESS) ? addr_q : '0;
   assign ram_wdata = (state == ACCESS) ? wdata_q : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         op_wr    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (found) begin
                  grant   <= winner;
                  op_wr   <= ch_wen[winner];
                  addr_q  <= ch_addr[winner*AW +: AW];
                  wdata_q <= ch_wdata[winner*DW +: DW];
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               if (done) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
                  rr_ptr   <= next_ptr;
               end else if (ram_busy) begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: A = fixed priority with TIMEOUT=4, B = round-robin without timeout, both NCH=3.
module tb_mem_port_arbiter;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   typedef struct {
      int          ch;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   int checks = 0;
   int errors = 0;
   int done_a = 0, done_b = 0;
   int cyc = 0;
   int last_a = -1;
   bit gap_a = 1'b0;

   logic [2:0]  a_ren, a_wen, a_ready, a_err, b_ren, b_wen, b_ready, b_err;
   logic [95:0] a_addr, a_wdata, b_addr, b_wdata;
   logic [31:0] a_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
   logic [31:0] b_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
   logic        a_ram_ren, a_ram_wen, a_ram_busy, b_ram_ren, b_ram_wen, b_ram_busy;
   int          a_wait, b_wait, a_bcnt = 0, b_bcnt = 0;

   mem_port_arbiter #(.NCH(3), .AW(32), .DW(32), .MODE(0), .TIMEOUT(4)) dut_a (
      .CLK(CLK), .nRST(nRST), .ch_ren(a_ren), .ch_wen(a_wen), .ch_addr(a_addr),
      .ch_wdata(a_wdata), .ch_ready(a_ready), .ch_err(a_err), .ch_rdata(a_rdata),
      .ram_ren(a_ram_ren), .ram_wen(a_ram_wen), .ram_addr(a_ram_addr),
      .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .ram_busy(a_ram_busy));

   mem_port_arbiter #(.NCH(3), .AW(32), .DW(32), .MODE(1), .TIMEOUT(0)) dut_b (
      .CLK(CLK), .nRST(nRST), .ch_ren(b_ren), .ch_wen(b_wen), .ch_addr(b_addr),
      .ch_wdata(b_wdata), .ch_ready(b_ready), .ch_err(b_err), .ch_rdata(b_rdata),
      .ram_ren(b_ram_ren), .ram_wen(b_ram_wen), .ram_addr(b_ram_addr),
      .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .ram_busy(b_ram_busy));

   // RAM models: busy for the first *_wait cycles of each command.
   assign a_ram_busy = (a_ram_ren || a_ram_wen) && (a_bcnt < a_wait);
   assign b_ram_busy = (b_ram_ren || b_ram_wen) && (b_bcnt < b_wait);
   always @(posedge CLK) begin
      a_bcnt <= ((a_ram_ren || a_ram_wen) && a_ram_busy) ? a_bcnt + 1 : 0;
      b_bcnt <= ((b_ram_ren || b_ram_wen) && b_ram_busy) ? b_bcnt + 1 : 0;
      cyc    <= cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_a(input int ch, input logic err, input logic [31:0] rd);
      exp_t e;
      e.ch = ch; e.err = err; e.rdata = rd;
      qa.push_back(e);
   endtask

   task automatic push_b(input int ch, input logic err, input logic [31:0] rd);
      exp_t e;
      e.ch = ch; e.err = err; e.rdata = rd;
      qb.push_back(e);
   endtask

   // Returns at posedge+1 of the cycle after the n-th completion.
   task automatic wait_done(input bit sel_b, input int n);
      int t;
      t = 0;
      do begin
         @(posedge CLK);
         t++;
      end while (((sel_b ? done_b : done_a) < n) && t < 200);
      if (t >= 200) check("wait_done_timeout", 64'(sel_b ? done_b : done_a), 64'(n));
      #1;
   endtask

   always @(negedge CLK) begin
      if (nRST) begin
         if (a_ready != 0 || a_err != 0) begin
            if (qa.size() == 0) check("a_unexpected_ready", 64'(a_ready), 0);
            else begin
               ea = qa.pop_front();
               check("a_ready", 64'(a_ready), 64'(1 << ea.ch));
               check("a_err", 64'(a_err), ea.err ? 64'(1 << ea.ch) : 64'd0);
               check("a_rdata", 64'(a_rdata), 64'(ea.rdata));
               done_a++;
               if (gap_a) begin
                  if (last_a >= 0) check("a_ready_gap", 64'(cyc - last_a), 64'd2);
                  last_a = cyc;
               end
            end
         end else begin
            check("a_rdata_idle", 64'(a_rdata), 0);
         end
         if (b_ready != 0 || b_err != 0) begin
            if (qb.size() == 0) check("b_unexpected_ready", 64'(b_ready), 0);
            else begin
               eb = qb.pop_front();
               check("b_ready", 64'(b_ready), 64'(1 << eb.ch));
               check("b_err", 64'(b_err), eb.err ? 64'(1 << eb.ch) : 64'd0);
               check("b_rdata", 64'(b_rdata), 64'(eb.rdata));
               done_b++;
            end
         end else begin
            check("b_rdata_idle", 64'(b_rdata), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      nRST = 1'b0;
      a_ren = '0; a_wen = '0; a_addr = '0; a_wdata = '0;
      b_ren = '0; b_wen = '0; b_addr = '0; b_wdata = '0;
      a_wait = 0; b_wait = 0;
      a_ram_rdata = 32'h1111_2222;
      b_ram_rdata = 32'hCAFE_0001;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_a_ram_ren", 64'(a_ram_ren), 0);
      check("rst_a_ram_wen", 64'(a_ram_wen), 0);
      check("rst_a_ram_addr", 64'(a_ram_addr), 0);
      check("rst_a_ram_wdata", 64'(a_ram_wdata), 0);
      check("rst_a_ready", 64'(a_ready), 0);
      check("rst_a_err", 64'(a_err), 0);
      check("rst_a_rdata", 64'(a_rdata), 0);
      check("rst_b_ram_ren", 64'(b_ram_ren), 0);
      check("rst_b_ready", 64'(b_ready), 0);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      // Fixed priority: ch0 wins while it requests, then ch1.
      for (int k = 0; k < 3; k++) push_a(0, 1'b0, 32'h1111_2222);
      gap_a = 1'b1;
      a_ren = 3'b111;
      wait_done(1'b0, 3);
      a_ren = 3'b110;
      push_a(1, 1'b0, 32'h1111_2222);
      wait_done(1'b0, 4);
      a_ren = 3'b000;
      gap_a = 1'b0;
      last_a = -1;

      // Read with three wait states.
      a_wait = 3;
      a_ram_rdata = 32'hDEAD_BEEF;
      a_addr[32 +: 32] = 32'h40;
      a_ren = 3'b010;
      push_a(1, 1'b0, 32'hDEAD_BEEF);
      @(negedge CLK);
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         check("ws_ram_addr", 64'(a_ram_addr), 64'h40);
         check("ws_ram_ren", 64'(a_ram_ren), 1);
      end
      wait_done(1'b0, 5);
      a_ren = 3'b000;
      a_wait = 0;

      // Write (ren+wen together) with wdata changed and request dropped mid-access.
      a_wait = 2;
      a_addr[0 +: 32] = 32'h100;
      a_wdata[0 +: 32] = 32'h1234_5678;
      a_ren = 3'b001;
      a_wen = 3'b001;
      push_a(0, 1'b0, 32'h0);
      @(negedge CLK);
      @(negedge CLK);
      check("wr_ram_wen", 64'(a_ram_wen), 1);
      check("wr_ram_ren", 64'(a_ram_ren), 0);
      check("wr_ram_addr", 64'(a_ram_addr), 64'h100);
      check("wr_ram_wdata", 64'(a_ram_wdata), 64'h1234_5678);
      a_wdata[0 +: 32] = 32'hFFFF_FFFF;
      a_ren = 3'b000;
      a_wen = 3'b000;
      @(negedge CLK);
      check("wr_wdata_stable", 64'(a_ram_wdata), 64'h1234_5678);
      check("wr_wen_held", 64'(a_ram_wen), 1);
      wait_done(1'b0, 6);
      a_wait = 0;

      // Timeout: RAM stuck busy, abort in the 4th access cycle.
      a_wait = 1000;
      a_addr[64 +: 32] = 32'h200;
      a_ren = 3'b100;
      push_a(2, 1'b1, 32'h0);
      @(negedge CLK);
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         check("to_ram_addr", 64'(a_ram_addr), 64'h200);
         check("to_ready_timing", 64'(a_ready), (k == 4) ? 64'd4 : 64'd0);
      end
      a_ren = 3'b000;
      @(negedge CLK);
      check("to_strobe_drop", 64'(a_ram_ren), 0);
      @(posedge CLK);
      #1;
      a_wait = 0;
      a_addr[64 +: 32] = 32'h204;
      a_ram_rdata = 32'h5555_AAAA;
      a_ren = 3'b100;
      push_a(2, 1'b0, 32'h5555_AAAA);
      wait_done(1'b0, 8);
      a_ren = 3'b000;

      // Round-robin with all channels requesting.
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 3; k++) push_b(k, 1'b0, 32'hCAFE_0001);
      b_ren = 3'b111;
      wait_done(1'b1, 6);
      b_ren = 3'b000;

      // Advance rr_ptr to 1, then reset in the middle of a ch1 access.
      b_ren = 3'b001;
      push_b(0, 1'b0, 32'hCAFE_0001);
      wait_done(1'b1, 7);
      b_ren = 3'b000;
      b_wait = 1000;
      b_addr[32 +: 32] = 32'h80;
      b_ren = 3'b010;
      @(negedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      check("mid_ram_ren", 64'(b_ram_ren), 1);
      check("mid_ram_addr", 64'(b_ram_addr), 64'h80);
      nRST = 1'b0;
      #1;
      check("arst_ram_ren", 64'(b_ram_ren), 0);
      check("arst_ram_addr", 64'(b_ram_addr), 0);
      check("arst_ready", 64'(b_ready), 0);
      check("arst_err", 64'(b_err), 0);
      b_ren = 3'b111;
      b_wait = 0;
      push_b(0, 1'b0, 32'hCAFE_0001);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      wait_done(1'b1, 8);
      b_ren = 3'b000;

      repeat (3) @(posedge CLK);
      #1;
      check("a_queue_empty", 64'(qa.size()), 0);
      check("b_queue_empty", 64'(qb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
